// File: rtl/image_control.sv
// Front-end sequencer for the 3x3 filter: rotates four line buffers and, once three
// lines are held, streams one 3-row x 3-pixel window per cycle for a full line.
module image_control #(
    parameter int unsigned LINE_W = 640
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_pixel_data,
    input  logic        i_pixel_data_valid,
    output logic [71:0] o_pixel_data,
    output logic        o_pixel_data_valid,
    output logic        o_intr
);

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned ROW_W  = 3 * PIX_W;
    localparam int unsigned NUM_LB = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned PTR_W  = $clog2(LINE_W);
    localparam int unsigned FILL_W = 12;

    localparam logic [PTR_W-1:0]  LAST_PIX    = PTR_W'(LINE_W - 1);
    localparam logic [FILL_W-1:0] READ_THRESH = FILL_W'(3 * LINE_W);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [PTR_W-1:0]             wr_pix_cnt;
    logic [PTR_W-1:0]             rd_pix_cnt;
    logic [SEL_W-1:0]             wr_sel;
    logic [SEL_W-1:0]             rd_sel;
    logic [SEL_W-1:0]             free_sel;
    logic [FILL_W-1:0]            fill_cnt;
    logic                         rd_active;
    logic                         line_done;
    logic [NUM_LB-1:0]            lb_wr_en;
    logic [NUM_LB-1:0]            lb_rd_en;
    logic [NUM_LB-1:0][ROW_W-1:0] lb_row;

    // Line-local pointer advance; wraps so a buffer always holds exactly one line.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PIX) ? '0 : p + PTR_W'(1);
    endfunction

    // Write side: pixel position within the line and the buffer being filled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_pix_cnt <= '0;
            wr_sel     <= '0;
        end else if (i_pixel_data_valid) begin
            if (wr_pix_cnt == LAST_PIX) begin
                wr_pix_cnt <= '0;
                wr_sel     <= wr_sel + SEL_W'(1);
            end else begin
                wr_pix_cnt <= wr_pix_cnt + PTR_W'(1);
            end
        end
    end

    // Occupancy: pixels stored but not yet consumed by a read burst.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fill_cnt <= '0;
        end else begin
            case ({i_pixel_data_valid, rd_active})
                2'b10:   fill_cnt <= fill_cnt + FILL_W'(1);
                2'b01:   fill_cnt <= fill_cnt - FILL_W'(1);
                default: fill_cnt <= fill_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A burst always runs a full line; it starts only from IDLE, so bursts are separated.
    always_comb begin
        state_nxt = state;
        rd_active = 1'b0;
        line_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (fill_cnt >= READ_THRESH) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                rd_active = 1'b1;
                if (rd_pix_cnt == LAST_PIX) begin
                    line_done = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read side: column position, oldest-line buffer select, line-consumed pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_pix_cnt <= '0;
            rd_sel     <= '0;
            o_intr     <= 1'b0;
        end else begin
            o_intr <= line_done;
            if (line_done) begin
                rd_pix_cnt <= '0;
                rd_sel     <= rd_sel + SEL_W'(1);
            end else if (rd_active) begin
                rd_pix_cnt <= rd_pix_cnt + PTR_W'(1);
            end
        end
    end

    assign free_sel           = rd_sel + SEL_W'(3);
    assign o_pixel_data_valid = (state == S_READ);

    // Only the buffer being filled sees the write strobe; the other three advance together.
    always_comb begin
        lb_wr_en = '0;
        lb_rd_en = '0;
        lb_wr_en[wr_sel] = i_pixel_data_valid;
        for (int b = 0; b < NUM_LB; b++) begin
            lb_rd_en[b] = rd_active && (SEL_W'(b) != free_sel);
        end
    end

    for (genvar b = 0; b < NUM_LB; b++) begin : g_lb
        logic [PIX_W-1:0] mem [LINE_W];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [PTR_W-1:0] rd_ptr1;
        logic [PTR_W-1:0] rd_ptr2;

        always_ff @(posedge i_clk) begin
            if (lb_wr_en[b]) begin
                mem[wr_ptr] <= i_pixel_data;
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (lb_wr_en[b]) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (lb_rd_en[b]) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
            end
        end

        // Three consecutive pixels from the current read position, wrapping within the line.
        assign rd_ptr1   = ptr_inc(rd_ptr);
        assign rd_ptr2   = ptr_inc(rd_ptr1);
        assign lb_row[b] = {mem[rd_ptr], mem[rd_ptr1], mem[rd_ptr2]};
    end

    // Oldest stored line on top, newest of the three at the bottom.
    always_comb begin
        case (rd_sel)
            2'd0:    o_pixel_data = {lb_row[0], lb_row[1], lb_row[2]};
            2'd1:    o_pixel_data = {lb_row[1], lb_row[2], lb_row[3]};
            2'd2:    o_pixel_data = {lb_row[2], lb_row[3], lb_row[0]};
            default: o_pixel_data = {lb_row[3], lb_row[0], lb_row[1]};
        endcase
    end

endmodule

// File: tb/tb_image_control.sv
// Self-checking bench for image_control: randomized pixel streams against a
// line-level reference model of stored lines, occupancy and read bursts.
module tb_image_control;

    localparam int LINE_W    = 640;
    localparam int MAX_LINES = 16;
    localparam int THRESH    = 3 * LINE_W;

    logic        i_clk              = 1'b0;
    logic        i_rst              = 1'b1;
    logic [7:0]  i_pixel_data       = '0;
    logic        i_pixel_data_valid = 1'b0;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_intr;

    int checks   = 0;
    int failures = 0;

    // Reference model: every line ever written, plus which line triple is being read.
    logic [7:0] line_mem [MAX_LINES][LINE_W];
    int   m_wr_line    = 0;
    int   m_wr_pos     = 0;
    int   m_rd_line    = 0;
    int   m_rd_pos     = 0;
    int   m_fill       = 0;
    int   m_burst_left = 0;
    logic m_intr       = 1'b0;

    image_control #(.LINE_W(LINE_W)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_pixel_data       (i_pixel_data),
        .i_pixel_data_valid (i_pixel_data_valid),
        .o_pixel_data       (o_pixel_data),
        .o_pixel_data_valid (o_pixel_data_valid),
        .o_intr             (o_intr)
    );

    always #5 i_clk = ~i_clk;

    // Window for the current burst column: lines r, r+1, r+2, pixels p..p+2 within each line.
    function automatic logic [71:0] exp_window();
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w[71 - 8 * (3 * r + c) -: 8] =
                    line_mem[(m_rd_line + r) % MAX_LINES][(m_rd_pos + c) % LINE_W];
            end
        end
        return w;
    endfunction

    // Drive one clock worth of inputs, advance the model across the edge, sample at negedge.
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        bit rd;
        i_rst              = r;
        i_pixel_data_valid = v;
        i_pixel_data       = d;
        rd = (m_burst_left > 0);
        if (r) begin
            m_wr_line = 0; m_wr_pos = 0; m_rd_line = 0; m_rd_pos = 0;
            m_fill = 0; m_burst_left = 0; m_intr = 1'b0;
        end else begin
            m_intr = (m_burst_left == 1);
            if (v) begin
                line_mem[m_wr_line % MAX_LINES][m_wr_pos] = d;
                m_wr_pos++;
                if (m_wr_pos == LINE_W) begin
                    m_wr_pos = 0;
                    m_wr_line++;
                end
            end
            if (rd) begin
                m_burst_left--;
                m_rd_pos++;
                if (m_burst_left == 0) begin
                    m_rd_pos = 0;
                    m_rd_line++;
                end
            end else if (m_fill >= THRESH) begin
                m_burst_left = LINE_W;
            end
            m_fill = m_fill + (v ? 1 : 0) - (rd ? 1 : 0);
        end
        @(negedge i_clk);
    endtask

    task automatic write_const_line(input logic [7:0] val);
        for (int j = 0; j < LINE_W; j++) step(1'b0, 1'b1, val);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) step(1'b1, 1'($urandom), 8'($urandom));
        checks++;
        if (o_pixel_data_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b expected 0", o_pixel_data_valid);
        end
        checks++;
        if (o_intr !== 1'b0) begin
            failures++; $display("FAIL reset_intr: got %b expected 0", o_intr);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 8'h00);
            checks++;
            if (o_pixel_data_valid !== 1'b0) begin
                failures++; $display("FAIL reset_idle_valid: cycle %0d got %b expected 0", i, o_pixel_data_valid);
            end
        end
    endtask

    task automatic test_first_window();
        int n;
        write_const_line(8'h10);
        write_const_line(8'h20);
        write_const_line(8'h30);
        checks++;
        if (o_pixel_data_valid !== 1'b0) begin
            failures++; $display("FAIL first_early: got valid %b expected 0", o_pixel_data_valid);
        end
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (o_pixel_data_valid !== 1'b1) begin
            failures++; $display("FAIL first_latency: got valid %b expected 1", o_pixel_data_valid);
        end
        n = 0;
        while (o_pixel_data_valid === 1'b1 && n < LINE_W + 8) begin
            checks++;
            if (o_pixel_data !== 72'h101010_202020_303030) begin
                failures++; $display("FAIL first_data: col %0d got %h expected 101010202020303030", n, o_pixel_data);
            end
            step(1'b0, 1'b0, 8'h00);
            n++;
        end
        checks++;
        if (n != LINE_W) begin
            failures++; $display("FAIL first_burst_len: got %0d expected %0d", n, LINE_W);
        end
        checks++;
        if (o_intr !== 1'b1) begin
            failures++; $display("FAIL first_intr: got %b expected 1", o_intr);
        end
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (o_intr !== 1'b0) begin
            failures++; $display("FAIL first_intr_width: got %b expected 0", o_intr);
        end
    endtask

    task automatic test_line_advance();
        int n;
        write_const_line(8'h40);
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (o_pixel_data_valid !== 1'b1) begin
            failures++; $display("FAIL adv_latency: got valid %b expected 1", o_pixel_data_valid);
        end
        n = 0;
        while (o_pixel_data_valid === 1'b1 && n < LINE_W + 8) begin
            checks++;
            if (o_pixel_data !== 72'h202020_303030_404040) begin
                failures++; $display("FAIL adv_data: col %0d got %h expected 202020303030404040", n, o_pixel_data);
            end
            step(1'b0, 1'b0, 8'h00);
            n++;
        end
        checks++;
        if (n != LINE_W || o_intr !== 1'b1) begin
            failures++; $display("FAIL adv_burst: got len %0d intr %b expected len %0d intr 1", n, o_intr, LINE_W);
        end
    endtask

    task automatic test_pixel_order();
        logic [71:0] w;
        logic [23:0] exp_top;
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        for (int j = 0; j < LINE_W; j++) step(1'b0, 1'b1, 8'(j));
        write_const_line(8'h00);
        write_const_line(8'h00);
        step(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < LINE_W; k++) begin
            w = exp_window();
            exp_top = (k < LINE_W - 2) ? {8'(k), 8'(k + 1), 8'(k + 2)} : w[71:48];
            checks++;
            if (o_pixel_data_valid !== 1'b1 || o_pixel_data[71:48] !== exp_top || o_pixel_data[47:0] !== 48'h0) begin
                failures++;
                $display("FAIL order: col %0d got valid %b data %h expected valid 1 top %h rest 0",
                         k, o_pixel_data_valid, o_pixel_data, exp_top);
            end
            step(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        int   last_v1, first_v2, rises;
        logic prev_v;
        bit   done;
        step(1'b1, 1'b0, 8'h00);
        last_v1 = -1; first_v2 = -1; rises = 0; prev_v = 1'b0; done = 1'b0;
        for (int n = 0; n < 6000 && !done; n++) begin
            checks++;
            if (o_pixel_data_valid !== (m_burst_left > 0) || o_intr !== m_intr || dut.fill_cnt !== 12'(m_fill)) begin
                failures++;
                $display("FAIL b2b_ctrl: cycle %0d got valid %b intr %b fill %0d expected valid %b intr %b fill %0d",
                         n, o_pixel_data_valid, o_intr, dut.fill_cnt, (m_burst_left > 0), m_intr, m_fill);
            end
            if (m_burst_left > 0) begin
                checks++;
                if (o_pixel_data !== exp_window()) begin
                    failures++; $display("FAIL b2b_data: cycle %0d got %h expected %h", n, o_pixel_data, exp_window());
                end
            end
            if (o_pixel_data_valid === 1'b1 && prev_v == 1'b0) begin
                rises++;
                if (rises == 2) first_v2 = n;
            end
            if (o_pixel_data_valid === 1'b0 && prev_v == 1'b1 && last_v1 < 0) last_v1 = n - 1;
            prev_v = o_pixel_data_valid;
            done = (m_wr_line >= 4 && m_burst_left == 0 && m_fill < THRESH);
            if (!done) step(1'b0, 1'(m_wr_line < 4), 8'($urandom));
        end
        checks++;
        if (!done || first_v2 - last_v1 != 2) begin
            failures++;
            $display("FAIL b2b_gap: done %b got second burst %0d cycles after first ended expected 2", done, first_v2 - last_v1);
        end
    endtask

    task automatic test_random();
        bit done;
        bit ok;
        step(1'b1, 1'b0, 8'h00);
        done = 1'b0;
        for (int n = 0; n < 20000 && !done; n++) begin
            checks++;
            if (o_pixel_data_valid !== (m_burst_left > 0) || o_intr !== m_intr || dut.fill_cnt !== 12'(m_fill)) begin
                failures++;
                $display("FAIL rand_ctrl: cycle %0d got valid %b intr %b fill %0d expected valid %b intr %b fill %0d",
                         n, o_pixel_data_valid, o_intr, dut.fill_cnt, (m_burst_left > 0), m_intr, m_fill);
            end
            if (m_burst_left > 0) begin
                checks++;
                if (o_pixel_data !== exp_window()) begin
                    failures++; $display("FAIL rand_data: cycle %0d got %h expected %h", n, o_pixel_data, exp_window());
                end
            end
            done = (m_wr_line >= 8 && m_burst_left == 0 && m_fill < THRESH);
            // Never start a line whose buffer still holds a line awaiting its last burst.
            ok = (m_wr_line < 8) && (m_wr_line < 4 || m_rd_line >= m_wr_line - 3);
            if (!done) step(1'b0, 1'(ok && ($urandom_range(3) != 0)), 8'($urandom));
        end
        checks++;
        if (!done) begin
            failures++; $display("FAIL rand_timeout: got done 0 expected 1 (lines %0d read %0d)", m_wr_line, m_rd_line);
        end
    endtask

    task automatic test_reset_mid_read();
        int          n;
        logic [23:0] exp_top;
        step(1'b1, 1'b0, 8'h00);
        while (m_wr_line < 3) step(1'b0, 1'b1, 8'($urandom));
        for (n = 0; n < 8 && o_pixel_data_valid !== 1'b1; n++) step(1'b0, 1'b0, 8'h00);
        checks++;
        if (o_pixel_data_valid !== 1'b1) begin
            failures++; $display("FAIL mid_start: got valid %b expected 1", o_pixel_data_valid);
        end
        for (int k = 0; k < 300; k++) begin
            checks++;
            if (o_pixel_data !== exp_window()) begin
                failures++; $display("FAIL mid_data: col %0d got %h expected %h", k, o_pixel_data, exp_window());
            end
            step(1'b0, 1'b0, 8'h00);
        end
        step(1'b1, 1'b0, 8'h00);
        checks++;
        if (o_pixel_data_valid !== 1'b0 || o_intr !== 1'b0) begin
            failures++; $display("FAIL mid_abort: got valid %b intr %b expected 0 0", o_pixel_data_valid, o_intr);
        end
        while (m_wr_line < 3) begin
            step(1'b0, 1'b1, 8'($urandom));
            checks++;
            if (o_intr !== 1'b0 || o_pixel_data_valid !== m_burst_left > 0) begin
                failures++;
                $display("FAIL mid_refill: pixel %0d got valid %b intr %b expected valid %b intr 0",
                         m_wr_line * LINE_W + m_wr_pos, o_pixel_data_valid, o_intr, m_burst_left > 0);
            end
        end
        step(1'b0, 1'b0, 8'h00);
        exp_top = {line_mem[0][0], line_mem[0][1], line_mem[0][2]};
        checks++;
        if (o_pixel_data_valid !== 1'b1 || o_pixel_data[71:48] !== exp_top || o_pixel_data !== exp_window()) begin
            failures++;
            $display("FAIL mid_restart: got valid %b data %h expected valid 1 data %h",
                     o_pixel_data_valid, o_pixel_data, exp_window());
        end
    endtask

    initial begin
        test_reset();
        test_first_window();
        test_line_advance();
        test_pixel_order();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
